// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data memory arbiter.
// The arbiter takes the slave view; whatever drives the requesters and the memory takes master.
interface dmem_arbiter_if;
  logic        p_req;
  logic        p_wren;
  logic [11:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_gnt;
  logic        p_stall;
  logic        p_rvalid;
  logic [31:0] p_rdata;

  logic        x_req;
  logic        x_wren;
  logic [11:0] x_addr;
  logic [31:0] x_wdata;
  logic        x_gnt;
  logic        x_rvalid;
  logic [31:0] x_rdata;

  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  modport slave (
    input  p_req, p_wren, p_addr, p_wdata,
    input  x_req, x_wren, x_addr, x_wdata,
    input  mem_q,
    output p_gnt, p_stall, p_rvalid, p_rdata,
    output x_gnt, x_rvalid, x_rdata,
    output mem_address, mem_data, mem_wren
  );

  modport master (
    output p_req, p_wren, p_addr, p_wdata,
    output x_req, x_wren, x_addr, x_wdata,
    output mem_q,
    input  p_gnt, p_stall, p_rvalid, p_rdata,
    input  x_gnt, x_rvalid, x_rdata,
    input  mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the processor (fixed priority) and a
// secondary master, with a bounded wait for the secondary and read-data steering.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        rd_owner;
  logic              p_gnt;
  logic              x_gnt;
  logic              p_rvalid;
  logic              x_rvalid;

  always_comb begin
    p_gnt = 1'b0;
    x_gnt = 1'b0;
    if (!reset) begin
      if (bus.x_req && (!bus.p_req || wait_cnt == WAIT_LIMIT))
        x_gnt = 1'b1;
      else if (bus.p_req)
        p_gnt = 1'b1;
    end
  end

  always_comb begin
    bus.mem_address = '0;
    bus.mem_data    = '0;
    bus.mem_wren    = 1'b0;
    if (p_gnt) begin
      bus.mem_address = bus.p_addr;
      bus.mem_data    = bus.p_wdata;
      bus.mem_wren    = bus.p_wren;
    end else if (x_gnt) begin
      bus.mem_address = bus.x_addr;
      bus.mem_data    = bus.x_wdata;
      bus.mem_wren    = bus.x_wren;
    end
  end

  // wait_cnt never passes WAIT_LIMIT: at the limit X wins the next conflict and clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      rd_owner <= 2'b00;
    end else begin
      rd_owner <= {x_gnt & ~bus.x_wren, p_gnt & ~bus.p_wren};
      if (!bus.x_req || x_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIMIT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Gating with reset drops a read granted the cycle before reset asserts.
  assign p_rvalid     = rd_owner[0] & ~reset;
  assign x_rvalid     = rd_owner[1] & ~reset;

  assign bus.p_gnt    = p_gnt;
  assign bus.x_gnt    = x_gnt;
  assign bus.p_stall  = bus.p_req & ~p_gnt;
  assign bus.p_rvalid = p_rvalid;
  assign bus.x_rvalid = x_rvalid;
  assign bus.p_rdata  = p_rvalid ? bus.mem_q : '0;
  assign bus.x_rdata  = x_rvalid ? bus.mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a behavioural memory and a read-data scoreboard.
module tb_dmem_arbiter;

  logic clock;
  logic reset;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem_arr [0:4095];
  always @(posedge clock) begin
    bus.mem_q <= mem_arr[bus.mem_address];
    if (bus.mem_wren) mem_arr[bus.mem_address] <= bus.mem_data;
  end

  typedef struct {
    logic        rst;
    logic        p_req;
    logic        p_wren;
    logic [11:0] p_addr;
    logic [31:0] p_wdata;
    logic        x_req;
    logic        x_wren;
    logic [11:0] x_addr;
    logic [31:0] x_wdata;
    logic        e_p;
    logic        e_x;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] ref_mem [int];
  logic [31:0] pq [$];
  logic [31:0] xq [$];
  bit          exp_prv;
  bit          exp_xrv;
  int          n_checks;
  int          n_fail;

  function automatic vec_t mk(bit rst, bit pr, bit pw, logic [11:0] pa, logic [31:0] pd,
                              bit xr, bit xw, logic [11:0] xa, logic [31:0] xd,
                              bit ep, bit ex);
    vec_t v;
    v.rst = rst; v.p_req = pr; v.p_wren = pw; v.p_addr = pa; v.p_wdata = pd;
    v.x_req = xr; v.x_wren = xw; v.x_addr = xa; v.x_wdata = xd;
    v.e_p = ep; v.e_x = ex;
    return v;
  endfunction

  function automatic vec_t idle(bit rst);
    return mk(rst, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next rising edge.
  task automatic cycle(input vec_t v);
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic        e_wren;
    logic [31:0] d;
    reset       = v.rst;
    bus.p_req   = v.p_req;   bus.p_wren  = v.p_wren;
    bus.p_addr  = v.p_addr;  bus.p_wdata = v.p_wdata;
    bus.x_req   = v.x_req;   bus.x_wren  = v.x_wren;
    bus.x_addr  = v.x_addr;  bus.x_wdata = v.x_wdata;
    e_addr = v.e_p ? v.p_addr  : (v.e_x ? v.x_addr  : 12'h0);
    e_data = v.e_p ? v.p_wdata : (v.e_x ? v.x_wdata : 32'h0);
    e_wren = v.e_p ? v.p_wren  : (v.e_x ? v.x_wren  : 1'b0);
    @(negedge clock);
    check("p_gnt", bus.p_gnt, v.e_p);
    check("x_gnt", bus.x_gnt, v.e_x);
    check("p_stall", bus.p_stall, v.p_req & ~v.e_p);
    check("mem_wren", bus.mem_wren, e_wren);
    check("mem_address", bus.mem_address, e_addr);
    check("mem_data", bus.mem_data, e_data);
    if (v.rst) begin
      if (exp_prv) void'(pq.pop_front());
      if (exp_xrv) void'(xq.pop_front());
      exp_prv = 0;
      exp_xrv = 0;
    end
    check("p_rvalid", bus.p_rvalid, exp_prv);
    check("x_rvalid", bus.x_rvalid, exp_xrv);
    d = exp_prv ? pq.pop_front() : 32'h0;
    check("p_rdata", bus.p_rdata, d);
    d = exp_xrv ? xq.pop_front() : 32'h0;
    check("x_rdata", bus.x_rdata, d);
    exp_prv = v.e_p && !v.p_wren;
    exp_xrv = v.e_x && !v.x_wren;
    if (exp_prv) pq.push_back(ref_mem.exists(int'(v.p_addr)) ? ref_mem[int'(v.p_addr)] : 32'h0);
    if (exp_xrv) xq.push_back(ref_mem.exists(int'(v.x_addr)) ? ref_mem[int'(v.x_addr)] : 32'h0);
    if (v.e_p && v.p_wren) ref_mem[int'(v.p_addr)] = v.p_wdata;
    if (v.e_x && v.x_wren) ref_mem[int'(v.x_addr)] = v.x_wdata;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_prv  = 0;
    exp_xrv  = 0;

    // reset with idle inputs, once with requests during reset, then idle
    for (int i = 0; i < 5; i++) vecs.push_back(idle(1));
    vecs.push_back(mk(1, 1, 0, 12'h010, 32'h0, 1, 0, 12'h020, 32'h0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(idle(0));
    // preload words used by later reads
    vecs.push_back(mk(0, 0, 0, 12'h0, 32'h0, 1, 1, 12'h020, 32'h12345678, 0, 1));
    vecs.push_back(mk(0, 0, 0, 12'h0, 32'h0, 1, 1, 12'h200, 32'hA5A55A5A, 0, 1));
    vecs.push_back(mk(0, 1, 1, 12'h021, 32'hCAFEF00D, 0, 0, 12'h0, 32'h0, 1, 0));
    // P write then read-back
    vecs.push_back(mk(0, 1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 1, 0));
    vecs.push_back(idle(0));
    // continuous conflict: X wins every fifth cycle
    for (int i = 1; i <= 10; i++)
      vecs.push_back(mk(0, 1, 1, 12'h300 + 12'(i), 32'h1000 + 32'(i), 1, 0, 12'h200, 32'h0,
                        (i % 5) != 0, (i % 5) == 0));
    vecs.push_back(idle(0));
    // X read then P read on consecutive cycles
    vecs.push_back(mk(0, 0, 0, 12'h0, 32'h0, 1, 0, 12'h020, 32'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 12'h021, 32'h0, 0, 0, 12'h0, 32'h0, 1, 0));
    // back-to-back read, write, read of the same word
    vecs.push_back(mk(0, 1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 12'h010, 32'h11112222, 0, 0, 12'h0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 1, 0));
    vecs.push_back(idle(0));

    reset = 1'b1;
    bus.p_req = 0; bus.p_wren = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.x_req = 0; bus.x_wren = 0; bus.x_addr = '0; bus.x_wdata = '0;
    @(posedge clock);
    #1;

    foreach (vecs[i]) cycle(vecs[i]);

    // single conflict: wait_cnt reaches 1, then clears on the X grant
    cycle(mk(0, 1, 1, 12'h400, 32'h77, 1, 0, 12'h020, 32'h0, 1, 0));
    check("wait_cnt_after_conflict", 32'(dut.wait_cnt), 32'd1);
    cycle(mk(0, 0, 0, 12'h0, 32'h0, 1, 0, 12'h020, 32'h0, 0, 1));
    check("wait_cnt_after_xgnt", 32'(dut.wait_cnt), 32'd0);
    cycle(idle(0));

    // read granted right before reset never returns data
    cycle(mk(0, 1, 0, 12'h021, 32'h0, 0, 0, 12'h0, 32'h0, 1, 0));
    cycle(idle(1));
    cycle(idle(0));
    cycle(mk(0, 1, 0, 12'h021, 32'h0, 0, 0, 12'h0, 32'h0, 1, 0));
    cycle(idle(0));
    cycle(idle(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
